// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
//   dmem_state_t : responder FSM states
//   dmem_req_t   : one latched request plus its precomputed error flag
//   SZ_*         : legal transfer sizes in bytes
//   size_ok      : 1 when a size is one of the legal transfer sizes
//   lane_mask    : byte-lane enables for a transfer that starts at lane 0
//   bit_mask     : lane_mask widened to one bit per data bit
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} dmem_state_t;

  localparam logic [3:0] SZ_B = 4'd1;
  localparam logic [3:0] SZ_H = 4'd2;
  localparam logic [3:0] SZ_W = 4'd4;
  localparam logic [3:0] SZ_D = 4'd8;

  typedef struct packed {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [3:0]  size;
    logic        err;
  } dmem_req_t;

  function automatic logic size_ok(input logic [3:0] size);
    return (size == SZ_B) || (size == SZ_H) || (size == SZ_W) || (size == SZ_D);
  endfunction

  function automatic logic [7:0] lane_mask(input logic [3:0] size);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      SZ_D:    m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  function automatic logic [63:0] bit_mask(input logic [3:0] size);
    logic [63:0] m;
    logic [7:0]  l;
    l = lane_mask(size);
    for (int k = 0; k < 8; k++) m[8*k +: 8] = {8{l[k]}};
    return m;
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// dmem_byte_array: little-endian byte storage organised as 64-bit words.
//   clk     : write clock
//   we_i    : per-byte-lane write enables for the addressed word
//   addr_i  : byte address; bits [2:0] are ignored (word-aligned base)
//   wdata_i : write bus, lane k carries the byte for base+k
//   rdata_o : combinational read of the addressed word
module dmem_byte_array #(
  parameter int unsigned DEPTH_BYTES = 1024
) (
  input  logic        clk,
  input  logic [7:0]  we_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] rdata_o
);

  localparam int unsigned WORDS = (DEPTH_BYTES / 8 > 1) ? DEPTH_BYTES / 8 : 1;
  localparam int unsigned IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [63:0]   mem_q [WORDS];
  logic [IW-1:0] idx;
  logic          unused_addr;

  assign idx         = addr_i[3 +: IW];
  assign unused_addr = ^{addr_i[63:3+IW], addr_i[2:0]};

  // NOTE: storage has no reset branch; contents survive reset and a reset
  // loop over every word would force flops instead of a RAM.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (we_i[k]) mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
    end
  end

  assign rdata_o = mem_q[idx];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the CPU data-memory interface.
// Accepts one load/store at a time, waits LATENCY cycles, then presents a
// response until the CPU takes it.
//   clk, reset          : clock, synchronous active-low reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   req_write           : 1 = store, 0 = load
//   req_addr/req_size   : byte address, transfer size (1/2/4/8)
//   req_wdata           : store data, least-significant bytes used
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : zero-extended load data, 0 for stores and errors
//   rsp_err             : bad size, misaligned or out of range
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LATENCY     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [3:0]  req_size,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  dmem_req_t   req_q, req_in, cur;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept, commit;
  logic [64:0] req_end;
  logic [2:0]  off;
  logic [7:0]  lane_we;
  logic [63:0] wbus, arr_rdata, load_data;

  assign accept = req_valid && (state_q == IDLE);

  // Range check runs on 65 bits so an address near 2^64 cannot wrap into range.
  assign req_end = {1'b0, req_addr} + {61'd0, req_size};
  assign req_in  = '{
    wr:    req_write,
    addr:  req_addr,
    wdata: req_wdata,
    size:  req_size,
    err:   !size_ok(req_size)
           || ((req_addr[3:0] & (req_size - 4'd1)) != 4'd0)
           || (req_end > 65'(DEPTH_BYTES))
  };

  // With LATENCY==1 the commit edge is the acceptance edge, so the request is
  // served straight from the inputs; otherwise from the latched copy.
  assign cur    = (state_q == IDLE) ? req_in : req_q;
  assign commit = ((state_q == BUSY) && (cnt_q == 4'd0)) || ((LATENCY == 1) && accept);

  // Legal accesses never cross an 8-byte word, so a lane shift suffices.
  assign off       = cur.addr[2:0];
  assign lane_we   = (commit && cur.wr && !cur.err) ? (lane_mask(cur.size) << off) : 8'h00;
  assign wbus      = cur.wdata << {off, 3'b000};
  assign load_data = (arr_rdata >> {off, 3'b000}) & bit_mask(cur.size);

  dmem_byte_array #(.DEPTH_BYTES(DEPTH_BYTES)) u_array (
    .clk     (clk),
    .we_i    (lane_we),
    .addr_i  ({cur.addr[63:3], 3'b000}),
    .wdata_i (wbus),
    .rdata_o (arr_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process order.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: combinational processes assign defaults first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (LATENCY == 1) ? RESP : BUSY;
      BUSY:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

  always_comb begin
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept)                                cnt_d = CNT_LOAD;
    else if ((state_q == BUSY) && (cnt_q != 4'd0)) cnt_d = cnt_q - 4'd1;
    if (commit) begin
      err_d   = cur.err;
      rdata_d = (cur.wr || cur.err) ? 64'd0 : load_data;
    end else if ((state_q == RESP) && rsp_ready) begin
      err_d   = 1'b0;
      rdata_d = 64'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= 4'd0;
      req_q   <= '0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) req_q <= req_in;
    end
  end

endmodule
